// File: rtl/wisc_pkg.sv
// Shared WISC-SP20 definitions: datapath width, opcode constants used by fetch
// and decode, and the fetch-stage state and PC-select encodings.
package wisc_pkg;

  localparam int unsigned XLEN = 16;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;

  typedef enum logic [1:0] {StReq, StWait, StHold, StHalted} fetch_state_e;

  typedef enum logic [1:0] {PcHold, PcInc, PcLoad} pc_sel_e;

  function automatic logic is_halt(logic [XLEN-1:0] inst);
    return inst[XLEN-1 -: 5] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode handoff, redirect
// input and status. master = fetch stage, slave = memory/decode environment.
// Optional FETCH_ALIGN_CHK_EN adds the fetch_misalign status flag.
interface fetch_stage_if;

  logic                       imem_req;
  logic [wisc_pkg::XLEN-1:0]  imem_addr;
  logic [wisc_pkg::XLEN-1:0]  imem_rdata;
  logic                       imem_done;
  logic                       dec_valid;
  logic                       dec_ready;
  logic [wisc_pkg::XLEN-1:0]  dec_inst;
  logic [wisc_pkg::XLEN-1:0]  dec_pc;
  logic [wisc_pkg::XLEN-1:0]  dec_pc_inc;
  logic                       redirect_valid;
  logic [wisc_pkg::XLEN-1:0]  redirect_pc;
  logic                       halted;
`ifdef FETCH_ALIGN_CHK_EN
  logic                       fetch_misalign;
`endif

  modport master (
`ifdef FETCH_ALIGN_CHK_EN
    output fetch_misalign,
`endif
    output imem_req, imem_addr, dec_valid, dec_inst, dec_pc, dec_pc_inc, halted,
    input  imem_rdata, imem_done, dec_ready, redirect_valid, redirect_pc
  );

  modport slave (
`ifdef FETCH_ALIGN_CHK_EN
    input  fetch_misalign,
`endif
    input  imem_req, imem_addr, dec_valid, dec_inst, dec_pc, dec_pc_inc, halted,
    output imem_rdata, imem_done, dec_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter for the fetch stage: PC register, next-PC select
// (hold / +PC_INC / redirect target) and the sequential-increment adder.
module fetch_pc_unit
  import wisc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_INC   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_e         pc_sel_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_inc_o
);

  logic [XLEN-1:0] pc_d, pc_q;

  // Modulo-2^16 add: wraps silently past 16'hFFFE.
  assign pc_inc_o = pc_q + XLEN'(PC_INC);
  assign pc_o     = pc_q;

  // Next-PC select.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel_i)
      PcInc:   pc_d = pc_inc_o;
      PcLoad:  pc_d = redirect_pc_i;
      default: pc_d = pc_q;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// WISC-SP20 instruction fetch stage. Issues one outstanding request at a time,
// buffers one instruction for decode, honours redirects and stops on HALT.
// Optional macro FETCH_ALIGN_CHK_EN: odd redirect targets halt fetch and set
// fetch_misalign instead of loading the PC.
module fetch_stage
  import wisc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000,
  parameter int unsigned     PC_INC   = 2
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  fetch_state_e    state_d, state_q;
  logic            squash_d, squash_q;
  logic            imem_req_d, imem_req_q;
  logic [XLEN-1:0] imem_addr_d, imem_addr_q;
  logic            dec_valid_d, dec_valid_q;
  logic [XLEN-1:0] dec_inst_d, dec_inst_q;
  logic [XLEN-1:0] dec_pc_d, dec_pc_q;
  logic [XLEN-1:0] dec_pc_inc_d, dec_pc_inc_q;
  logic            halted_d, halted_q;
  pc_sel_e         pc_sel;
  logic [XLEN-1:0] pc, pc_inc;

  fetch_pc_unit #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_sel_i      (pc_sel),
    .redirect_pc_i (bus.redirect_pc),
    .pc_o          (pc),
    .pc_inc_o      (pc_inc)
  );

`ifdef FETCH_ALIGN_CHK_EN
  logic misalign_d, misalign_q;
`endif

  // Next-state logic; redirect overrides the normal flow in every state.
  always_comb begin
    state_d      = state_q;
    squash_d     = squash_q;
    imem_req_d   = 1'b0;
    imem_addr_d  = imem_addr_q;
    dec_valid_d  = dec_valid_q;
    dec_inst_d   = dec_inst_q;
    dec_pc_d     = dec_pc_q;
    dec_pc_inc_d = dec_pc_inc_q;
    halted_d     = halted_q;
    pc_sel       = PcHold;
`ifdef FETCH_ALIGN_CHK_EN
    misalign_d   = misalign_q;
`endif

    unique case (state_q)
      StReq: begin
        imem_req_d  = 1'b1;
        imem_addr_d = pc;
        state_d     = StWait;
        // The request still goes out; its response gets dropped in WAIT.
        if (bus.redirect_valid) squash_d = 1'b1;
      end
      StWait: begin
        if (bus.imem_done) begin
          if (squash_q || bus.redirect_valid) begin
            squash_d = 1'b0;
            state_d  = StReq;
          end else begin
            dec_valid_d  = 1'b1;
            dec_inst_d   = bus.imem_rdata;
            dec_pc_d     = pc;
            dec_pc_inc_d = pc_inc;
            pc_sel       = PcInc;
            state_d      = StHold;
          end
        end else if (bus.redirect_valid) begin
          squash_d = 1'b1;
        end
      end
      StHold: begin
        if (bus.redirect_valid) begin
          dec_valid_d = 1'b0;
          state_d     = StReq;
        end else if (bus.dec_ready) begin
          dec_valid_d = 1'b0;
          if (is_halt(dec_inst_q)) begin
            halted_d = 1'b1;
            state_d  = StHalted;
          end else begin
            state_d  = StReq;
          end
        end
      end
      StHalted: begin
        if (bus.redirect_valid) begin
          halted_d = 1'b0;
          state_d  = StReq;
        end
      end
    endcase

    if (bus.redirect_valid) pc_sel = PcLoad;

`ifdef FETCH_ALIGN_CHK_EN
    // Odd target: keep the PC, drop everything in flight and stop fetching.
    if (bus.redirect_valid && bus.redirect_pc[0]) begin
      misalign_d  = 1'b1;
      pc_sel      = PcHold;
      state_d     = StHalted;
      halted_d    = 1'b1;
      dec_valid_d = 1'b0;
      squash_d    = 1'b0;
      imem_req_d  = 1'b0;
      imem_addr_d = imem_addr_q;
    end
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StReq;
      squash_q     <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      dec_valid_q  <= 1'b0;
      dec_inst_q   <= '0;
      dec_pc_q     <= '0;
      dec_pc_inc_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      squash_q     <= squash_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      dec_valid_q  <= dec_valid_d;
      dec_inst_q   <= dec_inst_d;
      dec_pc_q     <= dec_pc_d;
      dec_pc_inc_q <= dec_pc_inc_d;
      halted_q     <= halted_d;
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign bus.fetch_misalign = misalign_q;
`endif

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.dec_valid  = dec_valid_q;
  assign bus.dec_inst   = dec_inst_q;
  assign bus.dec_pc     = dec_pc_q;
  assign bus.dec_pc_inc = dec_pc_inc_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// stream (random latency, ready and redirects) against a PC-sequence model.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC (16'h0000),
    .PC_INC   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: never a HALT except at halt_at.
  logic [15:0] halt_at;
  function automatic logic [15:0] word_at(logic [15:0] a);
    logic [4:0] op;
    if (a == halt_at) return 16'h0000;
    op = (a[5:1] == 5'd0) ? 5'b00001 : a[5:1];
    return {op, a[10:0] ^ 11'h5A5};
  endfunction

  // Memory: one response, 'lat' cycles after a visible request.
  int unsigned mem_lat;
  bit          mem_rand_lat;
  int unsigned mem_cnt;
  logic [15:0] mem_addr_l;
  initial begin
    bus.imem_done  = 1'b0;
    bus.imem_rdata = 16'h0000;
    mem_cnt        = 0;
    mem_addr_l     = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_done = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.imem_done  = 1'b1;
          bus.imem_rdata = word_at(mem_addr_l);
        end
      end
      if (bus.imem_req) begin
        mem_addr_l = bus.imem_addr;
        mem_cnt    = mem_rand_lat ? $urandom_range(1, 4) : mem_lat;
      end
    end
  end

  task automatic apply_reset();
    rst_n              = 1'b0;
    bus.dec_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    // Long enough for any pending memory response to drain.
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n              = 1'b0;
    bus.dec_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    mem_lat = 1; mem_rand_lat = 0; halt_at = 16'h0001;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.dec_valid, bus.dec_inst, bus.dec_pc,
         bus.dec_pc_inc, bus.halted} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%h v=%b inst=%h pc=%h inc=%h h=%b, want all 0",
               bus.imem_req, bus.imem_addr, bus.dec_valid, bus.dec_inst, bus.dec_pc,
               bus.dec_pc_inc, bus.halted);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h, want 1/0000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] req_q[$];
    logic [15:0] pc_q[$];
    logic [15:0] inc_q[$];
    logic [15:0] inst_q[$];
    apply_reset();
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 40 && pc_q.size() < 2; i++) begin
      @(negedge clk);
      if (bus.imem_req) req_q.push_back(bus.imem_addr);
      if (bus.dec_valid) begin
        pc_q.push_back(bus.dec_pc);
        inc_q.push_back(bus.dec_pc_inc);
        inst_q.push_back(bus.dec_inst);
      end
    end
    bus.dec_ready = 1'b0;
    checks++;
    if (req_q.size() < 2 || pc_q.size() < 2) begin
      errors++;
      $display("FAIL seq_count: reqs=%0d handoffs=%0d, want >=2 each", req_q.size(), pc_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [15:0] a;
        a = 16'(2 * k);
        checks++;
        if (req_q[k] !== a) begin
          errors++;
          $display("FAIL seq_addr%0d: got %h want %h", k, req_q[k], a);
        end
        checks++;
        if (pc_q[k] !== a || inc_q[k] !== a + 16'd2) begin
          errors++;
          $display("FAIL seq_pc%0d: got pc=%h inc=%h want %h/%h", k, pc_q[k], inc_q[k], a,
                   a + 16'd2);
        end
        checks++;
        if (inst_q[k] !== word_at(a)) begin
          errors++;
          $display("FAIL seq_inst%0d: got %h want %h", k, inst_q[k], word_at(a));
        end
      end
    end
  endtask

  task automatic test_stall();
    bit found;
    int reqs;
    apply_reset();
    mem_lat = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.dec_valid) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stall_valid: dec_valid never rose, want 1");
    end
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.dec_valid !== 1'b1 || bus.dec_inst !== word_at(16'h0000)) begin
        errors++;
        $display("FAIL stall_hold: v=%b inst=%h want 1/%h", bus.dec_valid, bus.dec_inst,
                 word_at(16'h0000));
      end
      if (bus.imem_req) reqs++;
      @(negedge clk);
    end
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL stall_noreq: got %0d requests want 0", reqs);
    end
    bus.dec_ready = 1'b1;
    @(negedge clk);
    bus.dec_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req) found = 1;
    end
    checks++;
    if (!found || bus.imem_addr !== 16'h0002) begin
      errors++;
      $display("FAIL stall_next: req=%b addr=%h want 1/0002", found, bus.imem_addr);
    end
  endtask

  task automatic test_halt();
    bit found;
    int reqs;
    apply_reset();
    mem_lat = 1;
    halt_at = 16'h0004;
    bus.dec_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.halted) found = 1;
    end
    checks++;
    if (!found || bus.dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_set: halted=%b v=%b want 1/0", found, bus.dec_valid);
    end
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req) reqs++;
    end
    checks++;
    if (reqs != 0 || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_quiet: reqs=%0d halted=%b want 0/1", reqs, bus.halted);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0010;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_clear: halted=%b want 0", bus.halted);
    end
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req) found = 1;
    end
    checks++;
    if (!found || bus.imem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL halt_resume: req=%b addr=%h want 1/0010", found, bus.imem_addr);
    end
    bus.dec_ready = 1'b0;
    halt_at = 16'h0001;
  endtask

  // Redirect while a request is in flight; optionally check the wrapped link.
  task automatic test_redirect(input logic [15:0] tgt, input int unsigned lat, input string nm);
    bit found;
    bit leak;
    apply_reset();
    mem_lat = lat;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req) found = 1;
    end
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    found = 0;
    leak  = 0;
    for (int i = 0; i < 15 && !found; i++) begin
      if (bus.dec_valid) leak = 1;
      if (bus.imem_req) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (leak || !found || bus.imem_addr !== tgt) begin
      errors++;
      $display("FAIL %s_req: leak=%b req=%b addr=%h want 0/1/%h", nm, leak, found,
               bus.imem_addr, tgt);
    end
    found = 0;
    for (int i = 0; i < 15 && !found; i++) begin
      @(negedge clk);
      if (bus.dec_valid) found = 1;
    end
    checks++;
    if (!found || bus.dec_pc !== tgt || bus.dec_pc_inc !== tgt + 16'd2 ||
        bus.dec_inst !== word_at(tgt)) begin
      errors++;
      $display("FAIL %s_dec: v=%b pc=%h inc=%h inst=%h want %h/%h/%h", nm, found, bus.dec_pc,
               bus.dec_pc_inc, bus.dec_inst, tgt, tgt + 16'd2, word_at(tgt));
    end
    bus.dec_ready = 1'b1;
    @(negedge clk);
    bus.dec_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req) found = 1;
    end
    checks++;
    if (!found || bus.imem_addr !== tgt + 16'd2) begin
      errors++;
      $display("FAIL %s_next: req=%b addr=%h want 1/%h", nm, found, bus.imem_addr, tgt + 16'd2);
    end
  endtask

  task automatic test_reset_midflight();
    bit found;
    apply_reset();
    mem_lat = 6;
    bus.dec_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr != 16'h0000) found = 1;
    end
    bus.dec_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.dec_valid, bus.dec_inst, bus.dec_pc,
         bus.dec_pc_inc, bus.halted} !== '0) begin
      errors++;
      $display("FAIL midreset_zero: req=%b addr=%h v=%b inst=%h pc=%h inc=%h h=%b want all 0",
               bus.imem_req, bus.imem_addr, bus.dec_valid, bus.dec_inst, bus.dec_pc,
               bus.dec_pc_inc, bus.halted);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.imem_done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_late_done: done=%b want 1", bus.imem_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000 || bus.dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_restart: req=%b addr=%h v=%b want 1/0000/0", bus.imem_req,
               bus.imem_addr, bus.dec_valid);
    end
    found = 0;
    for (int i = 0; i < 15 && !found; i++) begin
      @(negedge clk);
      if (bus.dec_valid) found = 1;
    end
    checks++;
    if (!found || bus.dec_pc !== 16'h0000 || bus.dec_inst !== word_at(16'h0000)) begin
      errors++;
      $display("FAIL midreset_dec: v=%b pc=%h inst=%h want 1/0000/%h", found, bus.dec_pc,
               bus.dec_inst, word_at(16'h0000));
    end
  endtask

`ifdef FETCH_ALIGN_CHK_EN
  task automatic test_misalign();
    int reqs;
    apply_reset();
    mem_lat = 3;
    checks++;
    if (bus.fetch_misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_reset: got %b want 0", bus.fetch_misalign);
    end
    @(negedge clk);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0031;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.fetch_misalign !== 1'b1 || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL misalign_set: mis=%b halted=%b want 1/1", bus.fetch_misalign, bus.halted);
    end
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_req || bus.dec_valid) reqs++;
    end
    checks++;
    if (reqs != 0 || bus.fetch_misalign !== 1'b1) begin
      errors++;
      $display("FAIL misalign_quiet: activity=%0d mis=%b want 0/1", reqs, bus.fetch_misalign);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] tgt;
    bit          redir_prev;
    bit          rv;
    bit          rdy;
    int          handoffs;
    apply_reset();
    mem_rand_lat = 1;
    halt_at      = 16'h0001;
    exp_pc       = 16'h0000;
    redir_prev   = 0;
    handoffs     = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      // A request right after a redirect may carry the stale, squashed address.
      if (bus.imem_req && !redir_prev) begin
        checks++;
        if (bus.imem_addr !== exp_pc) begin
          errors++;
          $display("FAIL rand_addr c%0d: got %h want %h", c, bus.imem_addr, exp_pc);
        end
      end
      rv  = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      tgt = 16'($urandom) & 16'hFFFE;
      bus.redirect_valid = rv;
      bus.redirect_pc    = tgt;
      bus.dec_ready      = rdy;
      if (!rv && bus.dec_valid && rdy) begin
        checks++;
        if (bus.dec_pc !== exp_pc || bus.dec_pc_inc !== exp_pc + 16'd2 ||
            bus.dec_inst !== word_at(exp_pc)) begin
          errors++;
          $display("FAIL rand_dec c%0d: pc=%h inc=%h inst=%h want %h/%h/%h", c, bus.dec_pc,
                   bus.dec_pc_inc, bus.dec_inst, exp_pc, exp_pc + 16'd2, word_at(exp_pc));
        end
        exp_pc = exp_pc + 16'd2;
        handoffs++;
      end
      if (rv) exp_pc = tgt;
      redir_prev = rv;
    end
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b0;
    mem_rand_lat       = 0;
    checks++;
    if (handoffs < 40) begin
      errors++;
      $display("FAIL rand_progress: got %0d handoffs want >=40", handoffs);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_halt();
    test_redirect(16'h0040, 4, "redir_wait");
    test_redirect(16'hFFFE, 2, "redir_wrap");
    test_reset_midflight();
`ifdef FETCH_ALIGN_CHK_EN
    test_misalign();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
